// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with FWFT tx FIFO and break generator
// Defining UART_TX_CTS_EN adds cts_n_i, which must be low for a new frame to start.
module uart_tx_param #(
  parameter int DATA_MAX_W = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVS        = 16,
  parameter int BRK_W      = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ov_tick_i,
  input  logic                        enable_i,
`ifdef UART_TX_CTS_EN
  input  logic                        cts_n_i,
`endif
  input  logic [DATA_MAX_W-1:0]       data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [2:0]                  data_width_i,
  input  logic [2:0]                  parity_i,
  input  logic [1:0]                  stop_i,
  input  logic                        brk_req_i,
  input  logic [BRK_W-1:0]            brk_len_i,
  output logic                        brk_done_o,
  output logic                        frame_done_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic                        tx_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(2 * OVS) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state_q, state_d;

  logic [DATA_MAX_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  push, pop, empty, full, can_start;

  assign full         = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign ready_o      = !full;
  assign push         = valid_i && !full;
  assign fifo_level_o = count;
  assign busy_o       = (state_q != IDLE);

`ifdef UART_TX_CTS_EN
  assign can_start = !empty && enable_i && !cts_n_i;
`else
  assign can_start = !empty && enable_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_i;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Frame shadow: word, length, parity and stop mode are frozen when the word is popped.
  logic [DATA_MAX_W-1:0] shift_q, head, head_masked;
  logic [3:0]            nbits_q, nbits_d, width_sum;
  logic                  par_en_q, par_bit_q, par_bit_d;
  logic [1:0]            stop_q;
  logic [BRK_W-1:0]      bit_cnt_q, brk_len_q;
  logic                  brk_hi_q;
  logic [TW-1:0]         tick_q, tick_lim;
  logic                  bit_end, data_last, brk_last;
  logic                  tx_line, frame_end, brk_end;

  assign head      = mem[rd_ptr];
  assign width_sum = {1'b0, data_width_i} + 4'd5;
  assign nbits_d   = (width_sum > 4'(DATA_MAX_W)) ? 4'(DATA_MAX_W) : width_sum;

  always_comb begin
    for (int i = 0; i < DATA_MAX_W; i++)
      head_masked[i] = head[i] && (i < int'(nbits_d));
    case (parity_i[1:0])
      2'd0:    par_bit_d = ^head_masked;
      2'd1:    par_bit_d = ~^head_masked;
      2'd2:    par_bit_d = 1'b1;
      default: par_bit_d = 1'b0;
    endcase
  end

  // Stop bits stretch the bit period to 1.5 or 2 bit times; every other bit is OVS ticks.
  always_comb begin
    tick_lim = TW'(OVS);
    if (state_q == STOP) begin
      case (stop_q)
        2'd1:    tick_lim = TW'(3 * OVS / 2);
        2'd2:    tick_lim = TW'(2 * OVS);
        default: tick_lim = TW'(OVS);
      endcase
    end
  end

  assign bit_end   = ov_tick_i && (tick_q == tick_lim - 1'b1);
  assign data_last = (bit_cnt_q == BRK_W'(nbits_q) - 1'b1);
  assign brk_last  = (bit_cnt_q == brk_len_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    tx_line   = 1'b1;
    frame_end = 1'b0;
    brk_end   = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_start) begin
          state_d = START;
          pop     = 1'b1;
        end else if (brk_req_i && empty) begin
          state_d = BREAK;
        end
      end
      START: begin
        tx_line = 1'b0;
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        tx_line = shift_q[0];
        if (bit_end && data_last) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_line = par_bit_q;
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) begin
          frame_end = 1'b1;
          if (can_start) begin
            state_d = START;
            pop     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        tx_line = brk_hi_q;
        if (bit_end && brk_hi_q) begin
          brk_end = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      tick_q       <= '0;
      shift_q      <= '0;
      nbits_q      <= 4'd5;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop_q       <= 2'd0;
      bit_cnt_q    <= '0;
      brk_len_q    <= BRK_W'(1);
      brk_hi_q     <= 1'b0;
      tx_o         <= 1'b1;
      frame_done_o <= 1'b0;
      brk_done_o   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_o         <= tx_line;
      frame_done_o <= frame_end;
      brk_done_o   <= brk_end;
      if (bit_end || state_q == IDLE) tick_q <= '0;
      else if (ov_tick_i)             tick_q <= tick_q + 1'b1;
      if (pop) begin
        shift_q   <= head;
        nbits_q   <= nbits_d;
        par_en_q  <= parity_i[2];
        par_bit_q <= par_bit_d;
        stop_q    <= stop_i;
        bit_cnt_q <= '0;
      end else if (state_q == IDLE && state_d == BREAK) begin
        brk_len_q <= (brk_len_i == '0) ? BRK_W'(1) : brk_len_i;
        brk_hi_q  <= 1'b0;
        bit_cnt_q <= '0;
      end else if (bit_end && state_q == DATA) begin
        shift_q   <= shift_q >> 1;
        bit_cnt_q <= data_last ? '0 : bit_cnt_q + 1'b1;
      end else if (bit_end && state_q == BREAK && !brk_hi_q) begin
        if (brk_last) begin
          brk_hi_q  <= 1'b1;
          bit_cnt_q <= '0;
        end else begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param
// Expected line waveforms come from a per-frame bit-list model; OVS ticks per bit with ov_tick_i held high.
module tb_uart_tx_param;
  localparam int DW  = 8;
  localparam int OVS = 16;

  logic        clk_i = 1'b0;
  logic        rst_i, ov_tick_i, enable_i, valid_i, ready_o;
  logic [DW-1:0] data_i;
  logic [2:0]  data_width_i, parity_i;
  logic [1:0]  stop_i;
  logic        brk_req_i, brk_done_o, frame_done_o, busy_o, tx_o;
  logic [15:0] brk_len_i;
  logic [4:0]  fifo_level_o;
`ifdef UART_TX_CTS_EN
  logic        cts_n_i;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit   exp_tx[$];
  logic obs_tx[$];
  int   exp_fd[$], obs_fd[$], exp_bd[$], obs_bd[$];

  uart_tx_param dut (
    .clk_i(clk_i), .rst_i(rst_i), .ov_tick_i(ov_tick_i), .enable_i(enable_i),
`ifdef UART_TX_CTS_EN
    .cts_n_i(cts_n_i),
`endif
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_width_i(data_width_i), .parity_i(parity_i), .stop_i(stop_i),
    .brk_req_i(brk_req_i), .brk_len_i(brk_len_i), .brk_done_o(brk_done_o),
    .frame_done_o(frame_done_o), .busy_o(busy_o), .fifo_level_o(fifo_level_o), .tx_o(tx_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void clear_q();
    exp_tx.delete(); obs_tx.delete();
    exp_fd.delete(); obs_fd.delete(); exp_bd.delete(); obs_bd.delete();
  endfunction

  // One frame on the line: start, N data bits LSB first, optional parity, stop; done pulse on last stop sample.
  function automatic void add_frame(int w, int wsel, int par, int stp);
    int n = (wsel + 5 > DW) ? DW : wsel + 5;
    int ones = 0;
    int pb, stop_len;
    repeat (OVS) exp_tx.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      ones += (w >> i) & 1;
      repeat (OVS) exp_tx.push_back(bit'((w >> i) & 1));
    end
    if (par >= 4) begin
      case (par % 4)
        0: pb = ones % 2;
        1: pb = 1 - ones % 2;
        2: pb = 1;
        default: pb = 0;
      endcase
      repeat (OVS) exp_tx.push_back(bit'(pb));
    end
    stop_len = (stp == 1) ? OVS * 3 / 2 : (stp == 2) ? 2 * OVS : OVS;
    repeat (stop_len) exp_tx.push_back(1'b1);
    exp_fd.push_back(exp_tx.size() - 1);
  endfunction

  function automatic void add_break(int len);
    int l = (len == 0) ? 1 : len;
    repeat (l * OVS) exp_tx.push_back(1'b0);
    repeat (OVS) exp_tx.push_back(1'b1);
    exp_bd.push_back(exp_tx.size() - 1);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_tx.size(); i++)
      if (i >= obs_tx.size() || obs_tx[i] !== logic'(exp_tx[i])) return i;
    return (obs_tx.size() == exp_tx.size()) ? -1 : exp_tx.size();
  endfunction

  function automatic logic obs_at(int i);
    return (i >= 0 && i < obs_tx.size()) ? obs_tx[i] : 1'bx;
  endfunction

  function automatic logic exp_at(int i);
    return (i >= 0 && i < exp_tx.size()) ? logic'(exp_tx[i]) : 1'bx;
  endfunction

  function automatic bit pulses_ok();
    if (obs_fd.size() != exp_fd.size() || obs_bd.size() != exp_bd.size()) return 1'b0;
    foreach (exp_fd[i]) if (obs_fd[i] != exp_fd[i]) return 1'b0;
    foreach (exp_bd[i]) if (obs_bd[i] != exp_bd[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Waits (bounded) for the line to fall, then records n samples of tx_o and both done pulses.
  task automatic capture(int n, bit drop_brk);
    int w = 0;
    while (tx_o !== 1'b0 && w < 3000) begin
      @(negedge clk_i);
      w++;
    end
    if (tx_o === 1'b0) begin
      for (int i = 0; i < n; i++) begin
        obs_tx.push_back(tx_o);
        if (frame_done_o === 1'b1) obs_fd.push_back(i);
        if (brk_done_o === 1'b1) obs_bd.push_back(i);
        if (drop_brk && i == 0) brk_req_i = 1'b0;
        @(negedge clk_i);
      end
    end
  endtask

  task automatic push(int w);
    data_i  = DW'(w);
    valid_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic set_cfg(int wsel, int par, int stp);
    data_width_i = 3'(wsel);
    parity_i     = 3'(par);
    stop_i       = 2'(stp);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (fifo_level_o !== 5'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level_o); end
    n_cmp++;
    if (frame_done_o !== 1'b0 || brk_done_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_pulses: frame_done=%b brk_done=%b want 0 0", frame_done_o, brk_done_o);
    end
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL reset_idle_tx: got %b want 1", tx_o); end
  endtask

  task automatic test_8n1();
    int d;
    clear_q(); enable_i = 1'b1; set_cfg(3, 0, 0);
    push(8'hA5);
    add_frame(8'hA5, 3, 0, 0);
    capture(exp_tx.size(), 1'b0);
    n_cmp++; d = first_diff();
    if (d >= 0) begin
      n_bad++;
      $display("FAIL 8n1_line: sample %0d got %b want %b (%0d/%0d samples)", d, obs_at(d), exp_at(d), obs_tx.size(), exp_tx.size());
    end
    n_cmp++;
    if (!pulses_ok()) begin
      n_bad++; $display("FAIL 8n1_done: frame_done at %p want %p", obs_fd, exp_fd);
    end
  endtask

  task automatic test_parity_stop();
    int d;
    for (int k = 0; k < 2; k++) begin
      clear_q(); enable_i = 1'b1; set_cfg(2, 3'b100, (k == 0) ? 2 : 1);
      push(8'h3C);
      add_frame(8'h3C, 2, 3'b100, (k == 0) ? 2 : 1);
      capture(exp_tx.size(), 1'b0);
      n_cmp++; d = first_diff();
      if (d >= 0) begin
        n_bad++;
        $display("FAIL 7e_stop%0d_line: sample %0d got %b want %b", k, d, obs_at(d), exp_at(d));
      end
      n_cmp++;
      if (!pulses_ok()) begin
        n_bad++; $display("FAIL 7e_stop%0d_done: frame_done at %p want %p", k, obs_fd, exp_fd);
      end
    end
  endtask

  // Random word pairs: config is changed while the first frame is on the line and must only hit the second.
  task automatic test_random_config();
    int d, w1, w2, wa, pa, sa, wb, pb, sb;
    for (int k = 0; k < 5; k++) begin
      w1 = $urandom_range(0, 255); w2 = $urandom_range(0, 255);
      wa = $urandom_range(0, 7); pa = $urandom_range(0, 7); sa = $urandom_range(0, 3);
      wb = $urandom_range(0, 7); pb = $urandom_range(0, 7); sb = $urandom_range(0, 3);
      clear_q(); enable_i = 1'b1; set_cfg(wa, pa, sa);
      push(w1); push(w2);
      @(negedge clk_i);
      set_cfg(wb, pb, sb);
      add_frame(w1, wa, pa, sa); add_frame(w2, wb, pb, sb);
      capture(exp_tx.size(), 1'b0);
      n_cmp++; d = first_diff();
      if (d >= 0) begin
        n_bad++;
        $display("FAIL rand%0d_line: sample %0d got %b want %b (cfg %0d/%0d/%0d then %0d/%0d/%0d)",
                 k, d, obs_at(d), exp_at(d), wa, pa, sa, wb, pb, sb);
      end
      n_cmp++;
      if (!pulses_ok()) begin
        n_bad++; $display("FAIL rand%0d_done: frame_done at %p want %p", k, obs_fd, exp_fd);
      end
    end
  endtask

  task automatic test_fifo_full();
    int d, w;
    int words[$];
    clear_q(); enable_i = 1'b0; set_cfg(3, 0, 0);
    for (int i = 0; i < 16; i++) begin
      w = $urandom_range(0, 255);
      words.push_back(w);
      push(w);
    end
    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL full_ready: got %b want 0", ready_o); end
    push($urandom_range(0, 255));
    n_cmp++; if (fifo_level_o !== 5'd16) begin n_bad++; $display("FAIL full_drop: level %0d want 16", fifo_level_o); end
    // A push while full is dropped even though the first pop happens on the same edge.
    data_i = 8'hFF; valid_i = 1'b1; enable_i = 1'b1;
    @(negedge clk_i);
    valid_i = 1'b0;
    n_cmp++; if (fifo_level_o !== 5'd15) begin n_bad++; $display("FAIL full_pushpop: level %0d want 15", fifo_level_o); end
    foreach (words[i]) add_frame(words[i], 3, 0, 0);
    capture(exp_tx.size(), 1'b0);
    n_cmp++; d = first_diff();
    if (d >= 0) begin
      n_bad++;
      $display("FAIL b2b_line: sample %0d got %b want %b (%0d/%0d samples)", d, obs_at(d), exp_at(d), obs_tx.size(), exp_tx.size());
    end
    n_cmp++;
    if (!pulses_ok()) begin
      n_bad++; $display("FAIL b2b_done: frame_done at %p want %p", obs_fd, exp_fd);
    end
    repeat (40) @(negedge clk_i);
    n_cmp++;
    if (fifo_level_o !== 5'd0 || busy_o !== 1'b0 || tx_o !== 1'b1) begin
      n_bad++; $display("FAIL b2b_drain: level %0d busy %b tx %b want 0 0 1", fifo_level_o, busy_o, tx_o);
    end
  endtask

  task automatic test_break();
    int d, w1, w2;
    for (int k = 0; k < 2; k++) begin
      clear_q(); enable_i = 1'b1;
      brk_len_i = (k == 0) ? 16'd3 : 16'd0; brk_req_i = 1'b1;
      add_break((k == 0) ? 3 : 0);
      capture(exp_tx.size(), 1'b1);
      n_cmp++; d = first_diff();
      if (d >= 0) begin
        n_bad++; $display("FAIL brk%0d_line: sample %0d got %b want %b", k, d, obs_at(d), exp_at(d));
      end
      n_cmp++;
      if (!pulses_ok()) begin
        n_bad++; $display("FAIL brk%0d_done: brk_done at %p want %p", k, obs_bd, exp_bd);
      end
    end
    repeat (40) @(negedge clk_i);
    // Queued data is sent before a pending break.
    w1 = $urandom_range(0, 255); w2 = $urandom_range(0, 255);
    clear_q(); enable_i = 1'b0; set_cfg(3, 0, 0);
    push(w1); push(w2);
    brk_len_i = 16'd2; brk_req_i = 1'b1;
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0) begin
      n_bad++; $display("FAIL brk_holdoff: tx %b busy %b want 1 0", tx_o, busy_o);
    end
    enable_i = 1'b1;
    add_frame(w1, 3, 0, 0); add_frame(w2, 3, 0, 0);
    capture(exp_tx.size(), 1'b0);
    n_cmp++; d = first_diff();
    if (d >= 0) begin
      n_bad++; $display("FAIL brk_frames_line: sample %0d got %b want %b", d, obs_at(d), exp_at(d));
    end
    clear_q(); add_break(2);
    capture(exp_tx.size(), 1'b1);
    n_cmp++; d = first_diff();
    if (d >= 0 || !pulses_ok()) begin
      n_bad++; $display("FAIL brk_after_line: sample %0d got %b want %b, brk_done at %p want %p",
                        d, obs_at(d), exp_at(d), obs_bd, exp_bd);
    end
  endtask

  task automatic test_reset_mid();
    int w = 0;
    int fd_seen = 0;
    int low_seen = 0;
    enable_i = 1'b1; set_cfg(3, 0, 0); brk_req_i = 1'b0;
    push(8'h00); push(8'h5A);
    while (tx_o !== 1'b0 && w < 3000) begin @(negedge clk_i); w++; end
    repeat (OVS + 3 * OVS + 4) @(negedge clk_i);
    n_cmp++; if (fifo_level_o !== 5'd1) begin n_bad++; $display("FAIL rstmid_pre_level: got %0d want 1", fifo_level_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL rstmid_tx: got %b want 1", tx_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
    n_cmp++; if (fifo_level_o !== 5'd0) begin n_bad++; $display("FAIL rstmid_level: got %0d want 0", fifo_level_o); end
    rst_i = 1'b0;
    repeat (400) begin
      @(negedge clk_i);
      if (frame_done_o !== 1'b0) fd_seen++;
      if (tx_o !== 1'b1) low_seen++;
    end
    n_cmp++; if (fd_seen != 0) begin n_bad++; $display("FAIL rstmid_done: %0d frame_done pulses want 0", fd_seen); end
    n_cmp++; if (low_seen != 0) begin n_bad++; $display("FAIL rstmid_line: %0d non-idle samples want 0", low_seen); end
  endtask

  task automatic test_enable_mid();
    int d, w1, w2;
    int bad = 0;
    w1 = $urandom_range(0, 255); w2 = $urandom_range(0, 255);
    clear_q(); enable_i = 1'b1; set_cfg(3, 3'b101, 0);
    push(w1); push(w2);
    enable_i = 1'b0;
    add_frame(w1, 3, 3'b101, 0);
    capture(exp_tx.size(), 1'b0);
    n_cmp++; d = first_diff();
    if (d >= 0 || !pulses_ok()) begin
      n_bad++; $display("FAIL enmid_frame: sample %0d got %b want %b, frame_done at %p want %p",
                        d, obs_at(d), exp_at(d), obs_fd, exp_fd);
    end
    repeat (200) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL enmid_hold: %0d active samples want 0", bad); end
    n_cmp++; if (fifo_level_o !== 5'd1) begin n_bad++; $display("FAIL enmid_level: got %0d want 1", fifo_level_o); end
    clear_q(); enable_i = 1'b1;
    add_frame(w2, 3, 3'b101, 0);
    capture(exp_tx.size(), 1'b0);
    n_cmp++; d = first_diff();
    if (d >= 0) begin
      n_bad++; $display("FAIL enmid_resume: sample %0d got %b want %b", d, obs_at(d), exp_at(d));
    end
  endtask

`ifdef UART_TX_CTS_EN
  task automatic test_cts();
    int d, w1, w2;
    int bad = 0;
    w1 = $urandom_range(0, 255); w2 = $urandom_range(0, 255);
    clear_q(); enable_i = 1'b1; set_cfg(3, 0, 0); cts_n_i = 1'b1;
    push(w1); push(w2);
    repeat (100) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL cts_hold: %0d low samples want 0", bad); end
    cts_n_i = 1'b0;
    @(negedge clk_i);
    cts_n_i = 1'b1;
    add_frame(w1, 3, 0, 0);
    capture(exp_tx.size(), 1'b0);
    n_cmp++; d = first_diff();
    if (d >= 0) begin
      n_bad++; $display("FAIL cts_frame: sample %0d got %b want %b", d, obs_at(d), exp_at(d));
    end
    bad = 0;
    repeat (200) begin
      @(negedge clk_i);
      if (tx_o !== 1'b1) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL cts_next_held: %0d low samples want 0", bad); end
    clear_q(); cts_n_i = 1'b0;
    add_frame(w2, 3, 0, 0);
    capture(exp_tx.size(), 1'b0);
    n_cmp++; d = first_diff();
    if (d >= 0) begin
      n_bad++; $display("FAIL cts_release: sample %0d got %b want %b", d, obs_at(d), exp_at(d));
    end
  endtask
`endif

  initial begin
    rst_i = 1'b1; ov_tick_i = 1'b1; enable_i = 1'b0; valid_i = 1'b0; data_i = '0;
    data_width_i = 3'd3; parity_i = 3'd0; stop_i = 2'd0; brk_req_i = 1'b0; brk_len_i = 16'd1;
`ifdef UART_TX_CTS_EN
    cts_n_i = 1'b0;
`endif
    @(negedge clk_i);
    test_reset();
    test_8n1();
    test_parity_stop();
    test_random_config();
    test_fifo_full();
    test_break();
    test_enable_mid();
`ifdef UART_TX_CTS_EN
    test_cts();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
